// File: rtl/vc_wr_xbar_nxm.sv
// N-input, M-output write-request crossbar for the vector cache write path.
// Each request is steered to a bank by address bits (or an XOR fold of two
// address fields), a per-output round-robin arbiter picks one requester, and
// the winner is written into a registered per-output FIFO whose head drives
// the output. Per-output occupancy is exported for credit/debug use.
module vc_wr_xbar_nxm #(
  parameter int IN_NUM     = 4,
  parameter int OUT_NUM    = 4,
  parameter int ADDR_W     = 64,
  parameter int PLD_W      = 1024,
  parameter int SEL_LSB    = 62,
  parameter int HASH_MODE  = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int SEL_W     = $clog2(OUT_NUM),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_NUM-1:0]         in_vld,
  output logic [IN_NUM-1:0]         in_rdy,
  input  logic [IN_NUM*ADDR_W-1:0]  in_addr,
  input  logic [IN_NUM*PLD_W-1:0]   in_pld,
  output logic [OUT_NUM-1:0]        out_vld,
  input  logic [OUT_NUM-1:0]        out_rdy,
  output logic [OUT_NUM*ADDR_W-1:0] out_addr,
  output logic [OUT_NUM*PLD_W-1:0]  out_pld,
  output logic [OUT_NUM*CNT_W-1:0]  out_cnt
);

  localparam int PTR_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int FP_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + PLD_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Parameter sanity: the select field(s) must lie inside the address.
  if (HASH_MODE == 0 && SEL_LSB + SEL_W > ADDR_W) begin : g_chk_sel
    $error("vc_wr_xbar_nxm: select field exceeds ADDR_W");
  end
  if (HASH_MODE != 0 && SEL_LSB + 2 * SEL_W > ADDR_W) begin : g_chk_hash
    $error("vc_wr_xbar_nxm: hash fields exceed ADDR_W");
  end
  if ((1 << SEL_W) != OUT_NUM || OUT_NUM < 2) begin : g_chk_out
    $error("vc_wr_xbar_nxm: OUT_NUM must be a power of 2 and >= 2");
  end
  if (FIFO_DEPTH < 2 || IN_NUM < 1) begin : g_chk_depth
    $error("vc_wr_xbar_nxm: FIFO_DEPTH must be >= 2 and IN_NUM >= 1");
  end

  logic [ADDR_W-1:0] addr_a  [IN_NUM];
  logic [PLD_W-1:0]  pld_a   [IN_NUM];
  logic [SEL_W-1:0]  sel     [IN_NUM];

  logic [IN_NUM-1:0] req     [OUT_NUM];
  logic [OUT_NUM-1:0] gnt_vld;
  logic [OUT_NUM-1:0] push;
  logic [OUT_NUM-1:0] pop;
  logic [PTR_W-1:0]  gnt_idx [OUT_NUM];
  logic [PTR_W-1:0]  rr_ptr  [OUT_NUM];

  logic [CNT_W-1:0]  cnt     [OUT_NUM];
  logic [FP_W-1:0]   wr_ptr  [OUT_NUM];
  logic [FP_W-1:0]   rd_ptr  [OUT_NUM];
  logic [ENT_W-1:0]  mem     [OUT_NUM][FIFO_DEPTH];

  for (genvar i = 0; i < IN_NUM; i++) begin : g_in
    assign addr_a[i] = in_addr[i*ADDR_W +: ADDR_W];
    assign pld_a[i]  = in_pld[i*PLD_W +: PLD_W];
    if (HASH_MODE != 0) begin : g_hash
      assign sel[i] = in_addr[i*ADDR_W + SEL_LSB +: SEL_W]
                    ^ in_addr[i*ADDR_W + SEL_LSB + SEL_W +: SEL_W];
    end else begin : g_direct
      assign sel[i] = in_addr[i*ADDR_W + SEL_LSB +: SEL_W];
    end
  end

  // Per-output request set and round-robin pick starting at rr_ptr.
  always_comb begin
    logic [PTR_W:0] idx;
    idx = '0;
    for (int unsigned o = 0; o < OUT_NUM; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int unsigned i = 0; i < IN_NUM; i++) begin
        req[o][i] = in_vld[i] && (sel[i] == SEL_W'(o));
      end
      for (int unsigned k = 0; k < IN_NUM; k++) begin
        idx = {1'b0, rr_ptr[o]} + (PTR_W+1)'(k);
        if (idx >= (PTR_W+1)'(IN_NUM)) begin
          idx = idx - (PTR_W+1)'(IN_NUM);
        end
        if (!gnt_vld[o] && req[o][idx[PTR_W-1:0]]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx[PTR_W-1:0];
        end
      end
      // Full is judged on the registered count: a same-cycle pop frees no room.
      push[o] = gnt_vld[o] && (cnt[o] != FULL_CNT);
      pop[o]  = out_vld[o] && out_rdy[o];
    end
  end

  // An input is ready only when its target output granted it and pushes.
  always_comb begin
    in_rdy = '0;
    for (int unsigned i = 0; i < IN_NUM; i++) begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        if (push[o] && gnt_idx[o] == PTR_W'(i)) begin
          in_rdy[i] = 1'b1;
        end
      end
    end
  end

  // FIFO storage, pointers, occupancy and round-robin pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        rr_ptr[o] <= '0;
        cnt[o]    <= '0;
        wr_ptr[o] <= '0;
        rd_ptr[o] <= '0;
        for (int unsigned d = 0; d < FIFO_DEPTH; d++) begin
          mem[o][d] <= '0;
        end
      end
    end else begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        if (push[o]) begin
          mem[o][wr_ptr[o]] <= {addr_a[gnt_idx[o]], pld_a[gnt_idx[o]]};
          wr_ptr[o] <= (wr_ptr[o] == FP_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr[o] + 1'b1;
          rr_ptr[o] <= (gnt_idx[o] == PTR_W'(IN_NUM - 1)) ? '0 : gnt_idx[o] + 1'b1;
        end
        if (pop[o]) begin
          rd_ptr[o] <= (rd_ptr[o] == FP_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr[o] + 1'b1;
        end
        case ({push[o], pop[o]})
          2'b10:   cnt[o] <= cnt[o] + 1'b1;
          2'b01:   cnt[o] <= cnt[o] - 1'b1;
          default: cnt[o] <= cnt[o];
        endcase
      end
    end
  end

  // Head of each FIFO drives the output directly from storage.
  for (genvar o = 0; o < OUT_NUM; o++) begin : g_out
    assign out_vld[o]                     = (cnt[o] != '0);
    assign out_addr[o*ADDR_W +: ADDR_W]   = mem[o][rd_ptr[o]][ENT_W-1:PLD_W];
    assign out_pld[o*PLD_W +: PLD_W]      = mem[o][rd_ptr[o]][PLD_W-1:0];
    assign out_cnt[o*CNT_W +: CNT_W]      = cnt[o];
  end

  // FIFOs must never overflow or underflow.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        assert (!(push[o] && cnt[o] == FULL_CNT));
        assert (!(pop[o] && cnt[o] == '0));
      end
    end
  end

endmodule

// File: tb/tb_vc_wr_xbar_nxm.sv
// Bench for vc_wr_xbar_nxm: directed scenarios plus random traffic, checked
// against a queue-based model of the crossbar kept in the bench.
module tb_vc_wr_xbar_nxm;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int AW = 64;
  localparam int PW = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    in_vld, in_rdy;
  logic [N*AW-1:0] in_addr;
  logic [N*PW-1:0] in_pld;
  logic [M-1:0]    out_vld, out_rdy;
  logic [M*AW-1:0] out_addr;
  logic [M*PW-1:0] out_pld;
  logic [M*CW-1:0] out_cnt;

  logic [N-1:0]    h_in_vld, h_in_rdy;
  logic [N*AW-1:0] h_in_addr;
  logic [N*PW-1:0] h_in_pld;
  logic [M-1:0]    h_out_vld;
  logic [M*AW-1:0] h_out_addr;
  logic [M*PW-1:0] h_out_pld;
  logic [M*CW-1:0] h_out_cnt;

  vc_wr_xbar_nxm #(.IN_NUM(N), .OUT_NUM(M), .ADDR_W(AW), .PLD_W(PW),
                   .SEL_LSB(62), .HASH_MODE(0), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_addr(in_addr), .in_pld(in_pld), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_addr(out_addr), .out_pld(out_pld), .out_cnt(out_cnt));

  vc_wr_xbar_nxm #(.IN_NUM(N), .OUT_NUM(M), .ADDR_W(AW), .PLD_W(PW),
                   .SEL_LSB(60), .HASH_MODE(1), .FIFO_DEPTH(D)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_vld(h_in_vld), .in_rdy(h_in_rdy),
    .in_addr(h_in_addr), .in_pld(h_in_pld), .out_vld(h_out_vld), .out_rdy('1),
    .out_addr(h_out_addr), .out_pld(h_out_pld), .out_cnt(h_out_cnt));

  int checks = 0;
  int failures = 0;

  typedef logic [AW+PW-1:0] ent_t;
  ent_t mq[M][$];
  int   mptr[M];

  logic [N-1:0]  vld;
  logic [AW-1:0] addr_a[N];
  logic [PW-1:0] pld_a[N];
  logic [M-1:0]  ordy;

  logic [N-1:0]  s_rdy;
  logic [M-1:0]  s_vld;
  logic [CW-1:0] s_cnt[M];
  logic [PW-1:0] s_pld[M];

  task automatic chk(input string tag, input ent_t obs, input ent_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mk(input int i, input int s, input logic [PW-1:0] p);
    addr_a[i] = {$urandom, $urandom};
    addr_a[i][63:62] = 2'(s);
    pld_a[i] = p;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_addr[i*AW +: AW] = addr_a[i];
      in_pld[i*PW +: PW]  = pld_a[i];
    end
    in_vld  = vld;
    out_rdy = ordy;
  endtask

  task automatic model_reset();
    for (int o = 0; o < M; o++) begin
      mq[o].delete();
      mptr[o] = 0;
    end
  endtask

  // One clock of traffic: predict, compare, then advance the model.
  task automatic cycle();
    logic [N-1:0] erdy;
    int win[M];
    erdy = '0;
    for (int o = 0; o < M; o++) begin
      win[o] = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr[o] + k) % N;
        if (win[o] < 0 && vld[i] && addr_a[i][63:62] == 2'(o)) win[o] = i;
      end
      if (win[o] >= 0 && mq[o].size() < D) erdy[win[o]] = 1'b1;
      else win[o] = -1;
    end
    drive();
    #1;
    s_rdy = in_rdy;
    s_vld = out_vld;
    chk("in_rdy", ent_t'(in_rdy), ent_t'(erdy));
    for (int o = 0; o < M; o++) begin
      s_cnt[o] = out_cnt[o*CW +: CW];
      s_pld[o] = out_pld[o*PW +: PW];
      chk($sformatf("out_vld[%0d]", o), ent_t'(out_vld[o]), ent_t'(mq[o].size() != 0));
      chk($sformatf("out_cnt[%0d]", o), ent_t'(s_cnt[o]), ent_t'(mq[o].size()));
      if (mq[o].size() != 0) begin
        chk($sformatf("out_addr[%0d]", o), ent_t'(out_addr[o*AW +: AW]), ent_t'(mq[o][0][AW+PW-1:PW]));
        chk($sformatf("out_pld[%0d]", o), ent_t'(s_pld[o]), ent_t'(mq[o][0][PW-1:0]));
      end
    end
    @(posedge clk);
    for (int o = 0; o < M; o++) begin
      if (ordy[o] && mq[o].size() != 0) void'(mq[o].pop_front());
      if (win[o] >= 0) begin
        mq[o].push_back({addr_a[win[o]], pld_a[win[o]]});
        mptr[o] = (win[o] + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    vld = '0; ordy = '0;
    for (int i = 0; i < N; i++) mk(i, 0, '0);
    drive();
    h_in_vld = '0; h_in_addr = '0; h_in_pld = '0;
    model_reset();
    #12;
    chk("rst_out_vld", ent_t'(out_vld), '0);
    chk("rst_out_cnt", ent_t'(out_cnt), '0);
    chk("rst_in_rdy", ent_t'(in_rdy), '0);
    chk("rst_out_addr", ent_t'(out_addr[AW-1:0]), '0);
    chk("rst_out_pld", ent_t'(out_pld[PW-1:0]), '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request to output 2.
    vld = 4'b0001; mk(0, 2, 32'hA5); ordy = '0;
    cycle();
    chk("t1_rdy", ent_t'(s_rdy), ent_t'(4'b0001));
    vld = '0;
    cycle();
    chk("t1_vld", ent_t'(s_vld), ent_t'(4'b0100));
    chk("t1_pld", ent_t'(s_pld[2]), ent_t'(32'hA5));
    chk("t1_cnt", ent_t'(s_cnt[2]), ent_t'(1));
    ordy = '1;
    cycle();

    // All inputs contend for output 1; grants rotate 0,1,2,3,0...
    for (int c = 0; c < 8; c++) begin
      vld = '1;
      for (int i = 0; i < N; i++) mk(i, 1, 32'(c * 16 + i));
      cycle();
      chk("t2_grant", ent_t'(s_rdy), ent_t'(4'b0001 << (c % 4)));
      if (c > 0) chk("t2_cnt", ent_t'(s_cnt[1]), ent_t'(1));
    end
    vld = '0; cycle(); cycle();

    // Fill output 3 with back-pressure, then free one slot.
    ordy = 4'b0111; vld = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      mk(2, 3, 32'(32'h300 + c));
      cycle();
      chk("t3_rdy", ent_t'(s_rdy), ent_t'((c < 4) ? 4'b0100 : 4'b0000));
      if (c >= 4) chk("t3_full", ent_t'(s_cnt[3]), ent_t'(4));
    end
    ordy = 4'b1111; mk(2, 3, 32'h3AA);
    cycle();
    chk("t3_pop_cycle_rdy", ent_t'(s_rdy), '0);
    ordy = 4'b0111;
    cycle();
    chk("t3_resume_rdy", ent_t'(s_rdy), ent_t'(4'b0100));
    chk("t3_resume_cnt", ent_t'(s_cnt[3]), ent_t'(3));
    vld = '0; ordy = '1;
    for (int c = 0; c < 6; c++) cycle();

    // Four inputs to four distinct outputs at once.
    vld = '1;
    for (int i = 0; i < N; i++) mk(i, (i + 1) % M, 32'(32'h100 + i));
    cycle();
    chk("t4_rdy", ent_t'(s_rdy), ent_t'(4'hF));
    vld = '0;
    cycle();
    chk("t4_vld", ent_t'(s_vld), ent_t'(4'hF));
    for (int i = 0; i < N; i++)
      chk($sformatf("t4_pld[%0d]", (i + 1) % M), ent_t'(s_pld[(i + 1) % M]), ent_t'(32'h100 + i));

    // Hashed select: 2'b11 ^ 2'b01 lands on output 2.
    h_in_addr[AW-1:0] = {4'b1101, 28'h0, $urandom};
    h_in_pld[PW-1:0]  = 32'h5A;
    h_in_vld = 4'b0001;
    #1;
    chk("t5_rdy", ent_t'(h_in_rdy), ent_t'(4'b0001));
    @(posedge clk); #1;
    h_in_vld = '0;
    #1;
    chk("t5_vld", ent_t'(h_out_vld), ent_t'(4'b0100));
    chk("t5_pld", ent_t'(h_out_pld[2*PW +: PW]), ent_t'(32'h5A));
    @(posedge clk); #1;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom % 3) != 0;
        mk(i, int'($urandom % 4), $urandom);
      end
      for (int o = 0; o < M; o++) ordy[o] = (c % 100 < 50) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      cycle();
    end

    // Build up occupancy, then reset mid-cycle.
    ordy = '0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = 1'b1;
        mk(i, int'($urandom % 4), $urandom);
      end
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", ent_t'(out_vld), '0);
    chk("t6_rst_cnt", ent_t'(out_cnt), '0);
    model_reset();
    vld = '0; drive();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vld = 4'b0101; mk(0, 0, 32'hC0); mk(2, 0, 32'hC2); ordy = '1;
    cycle();
    chk("t6_rr_first", ent_t'(s_rdy), ent_t'(4'b0001));
    cycle();
    chk("t6_rr_second", ent_t'(s_rdy), ent_t'(4'b0100));
    vld = '0;
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_wr_xbar_nxm.md
Name: vc_wr_xbar_nxm

Overview:
Parametrised N-input, M-output write-request crossbar for the vector cache write path. It is the next generation of the fixed 4-output per-side write xbar. Each input request is steered to an output (hash bank) by address bits or an XOR-folded hash. A per-output round-robin arbiter selects among competing inputs, and each output has a registered FIFO so output back-pressure is decoupled from arbitration. Per-output occupancy counts are exported for credit and debug use.

Parameters:
IN_NUM, 4, number of request inputs (>=1)
OUT_NUM, 4, number of outputs/banks (power of 2, >=2)
ADDR_W, 64, request address width
PLD_W, 1024, payload width (data+strb+txnid+sideband, packed by the caller)
SEL_LSB, 62, LSB of the select field in the address
HASH_MODE, 0, 0: direct address bits; 1: XOR fold of two fields
FIFO_DEPTH, 4, entries per output FIFO (>=2)
Derived: SEL_W=$clog2(OUT_NUM); CNT_W=$clog2(FIFO_DEPTH+1)

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active low
in_vld  in  [IN_NUM]  request valid per input
in_rdy  out  [IN_NUM]  request accepted this cycle (in_vld&in_rdy = transfer)
in_addr  in  [ADDR_W] x IN_NUM  request address
in_pld  in  [PLD_W] x IN_NUM  request payload
out_vld  out  [OUT_NUM]  FIFO head valid per output
out_rdy  in  [OUT_NUM]  downstream accepts head
out_addr  out  [ADDR_W] x OUT_NUM  head address
out_pld  out  [PLD_W] x OUT_NUM  head payload
out_cnt  out  [CNT_W] x OUT_NUM  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, RR pointers=0, out_vld=0, out_cnt=0, out_addr/out_pld=0; in_rdy=0 because nothing is granted while empty-of-valid.
- Select: HASH_MODE=0 gives sel=in_addr[SEL_LSB+:SEL_W]. HASH_MODE=1 gives sel=in_addr[SEL_LSB+:SEL_W] ^ in_addr[SEL_LSB+SEL_W+:SEL_W]. The elaboration must fail if the field exceeds ADDR_W.
- Per output o: the request set is inputs with in_vld & sel==o. The RR arbiter has pointer ptr[o]. Priority order is ptr[o], ptr[o]+1, ..., wrapping mod IN_NUM. At most one grant per output per cycle.
- in_rdy[i]=1 only if input i is granted by its target output and that FIFO is not full (cnt<FIFO_DEPTH). No push-through on full: same-cycle pop does not free space for a push.
- in_rdy is combinational from in_vld/in_addr and registered state. in_vld must not depend on in_rdy.
- ptr[o] updates to (winner+1) mod IN_NUM only on an accepted push; it holds otherwise, including when the FIFO is full.
- FIFO: the push writes {addr,pld} at wr_ptr, and the pop occurs on out_vld&out_rdy. Pointers wrap from FIFO_DEPTH-1 to 0. out_cnt is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
- out_vld=(cnt!=0). Head outputs come directly from the storage read pointer. Minimum latency is 1 cycle from input acceptance to out_vld, with no bypass.
- Ordering: per input, requests to the same output leave in acceptance order. No ordering is guaranteed across outputs.
- Payload is held stable while out_vld&!out_rdy.
- out_rdy while out_vld=0 is ignored. A pop never underflows, and a push never overflows (assertions are required).
- Reset mid-operation discards all FIFO contents immediately.

Test Plan:
1. Single input 0, addr[63:62]=2'b10, pld=0xA5, HASH_MODE=0 -> in_rdy[0]=1 same cycle; next cycle out_vld=4'b0100, out_pld[2]=0xA5, out_cnt[2]=1.
2. All 4 inputs target output 1 continuously, out_rdy=1 -> grants rotate 0,1,2,3,0; each input is accepted once per 4 cycles; out_cnt[1] stays at 1.
3. out_rdy[3]=0, input 2 streams to output 3 with FIFO_DEPTH=4 -> 4 accepts, then in_rdy[2]=0 with out_cnt[3]=4. Raising out_rdy[3] for 1 cycle pops 1 entry; the push resumes the cycle after, and no push occurs in the pop cycle.
4. Four inputs to four distinct outputs in the same cycle -> all in_rdy=1; next cycle out_vld=4'hF with the correct pld routing.
5. HASH_MODE=1, SEL_LSB=60, addr[63:60]=4'b1101 -> sel=2'b11^2'b01=2'b10; the request appears on output 2.
6. rst_n low with out_cnt={2,1,0,3} -> out_vld=0 and out_cnt=0 asynchronously. After release, the first request to output 0 goes to input ptr 0.
